id_regfile_sb: RTL and testbench

Decode-stage register file for the MIPS pipeline: two combinational read ports addressed from the instruction's rs/rt fields and one synchronous write port from writeback. Adds three things to the basic decode register file: same-cycle write-to-read bypass, a pending-write scoreboard that raises a stall for load-use and other long-latency hazards, and a mode-selectable immediate extender. Sits between IF/ID and ID/EX; `stall` feeds the hazard unit.

---
 rtl/id_regfile_sb_if.sv | 33 +++
 rtl/id_regfile_sb.sv | 170 +++++++++++++++++
 tb/tb_id_regfile_sb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/id_regfile_sb_if.sv
// Decode register-file bundle: instruction fields, writeback port, scoreboard
// issue port and the read/extend/stall results returned to the pipeline.
interface id_regfile_sb_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       instruction;
  logic              uses_rt;
  logic [1:0]        ext_mode;
  logic              issue_pending;
  logic [4:0]        issue_dest;
  logic              RegWrite;
  logic [4:0]        write_register;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] extended_bits;
  logic              stall;
  logic [31:0]       pending_vec;

  // Pipeline side: IF/ID, hazard unit and writeback drive the requests.
  modport master (
    output instruction, uses_rt, ext_mode, issue_pending, issue_dest,
           RegWrite, write_register, write_data,
    input  read_data1, read_data2, extended_bits, stall, pending_vec
  );

  // Register-file side.
  modport slave (
    input  instruction, uses_rt, ext_mode, issue_pending, issue_dest,
           RegWrite, write_register, write_data,
    output read_data1, read_data2, extended_bits, stall, pending_vec
  );
endinterface

// File: rtl/id_regfile_sb.sv
// Decode-stage register file: two combinational read ports with same-cycle
// writeback bypass, one synchronous write port, a pending-write scoreboard
// that flags source hazards, and a mode-selectable immediate extender.
// The interface instance must be parameterised with the same DATA_W.
module id_regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 4000
) (
  input  logic           clk,
  input  logic           rst_n,
  id_regfile_sb_if.slave rf
);

  localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;
  localparam logic [1:0] EXT_SHAMT = 2'b11;

  // Sign-extend a 16-bit immediate to the datapath width.
  function automatic logic signed [DATA_W-1:0] ext_sign(input logic signed [15:0] v);
    return DATA_W'(v);
  endfunction

  // Zero-extend a 16-bit immediate.
  function automatic logic [DATA_W-1:0] ext_zero(input logic [15:0] v);
    return DATA_W'(v);
  endfunction

  // lui form: immediate in [31:16]; sign-extends from bit 31 on wide
  // datapaths and truncates on narrow ones.
  function automatic logic signed [DATA_W-1:0] ext_upper(input logic [15:0] v);
    logic signed [31:0] u;
    u = {v, 16'h0000};
    return DATA_W'(u);
  endfunction

  // Zero-extend the 5-bit shift amount.
  function automatic logic [DATA_W-1:0] ext_shamt(input logic [4:0] v);
    return DATA_W'(v);
  endfunction

  // Extender mode dispatch.
  function automatic logic [DATA_W-1:0] extend(input logic [1:0]  mode,
                                               input logic [15:0] v,
                                               input logic [4:0]  sh);
    logic [DATA_W-1:0] r;
    case (mode)
      EXT_SIGN:  r = ext_sign(v);
      EXT_ZERO:  r = ext_zero(v);
      EXT_UPPER: r = ext_upper(v);
      EXT_SHAMT: r = ext_shamt(sh);
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Instruction field decode.
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        unused_opcode;

  assign rs            = rf.instruction[25:21];
  assign rt            = rf.instruction[20:16];
  assign imm           = rf.instruction[15:0];
  assign shamt         = rf.instruction[10:6];
  assign unused_opcode = ^rf.instruction[31:26];

  // Write and scoreboard qualifiers. Only a clean 1 enables; X/Z reads as 0.
  logic wb_act;
  logic wr_en;
  logic iss_en;
  logic byp1;
  logic byp2;

  assign wb_act = (rf.RegWrite === 1'b1);
  assign wr_en  = wb_act && (rf.write_register != 5'd0);
  assign iss_en = (rf.issue_pending === 1'b1) && (rf.issue_dest != 5'd0);

  // Bypass is suppressed during reset so the reads reflect the cleared state.
  assign byp1 = rst_n && wr_en && (rf.write_register == rs);
  assign byp2 = rst_n && wr_en && (rf.write_register == rt);

  // Architectural register storage.
  logic [DATA_W-1:0] regs [0:31];

  // Storage: reset clears everything but the stack pointer; writes to r0 drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
    end else if (wr_en) begin
      regs[rf.write_register] <= rf.write_data;
    end
  end

  // Scoreboard: one bit per register with an outstanding late write.
  logic [31:0] pend_q;
  logic [31:0] pend_d;

  // Next scoreboard state: clear on writeback, then set on issue so that a
  // new producer issued on the same edge supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wb_act) begin
      pend_d[rf.write_register] = 1'b0;
    end
    if (iss_en) begin
      pend_d[rf.issue_dest] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Read ports: r0 hard-wired to zero, then bypass, then storage.
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Port 1 (rs) mux.
  always_comb begin
    rd1 = '0;
    if (rs == 5'd0) begin
      rd1 = '0;
    end else if (byp1) begin
      rd1 = rf.write_data;
    end else begin
      rd1 = regs[rs];
    end
  end

  // Port 2 (rt) mux.
  always_comb begin
    rd2 = '0;
    if (rt == 5'd0) begin
      rd2 = '0;
    end else if (byp2) begin
      rd2 = rf.write_data;
    end else begin
      rd2 = regs[rt];
    end
  end

  // Hazard detect: a pending source stalls unless writeback is delivering it
  // this very cycle through the bypass.
  logic haz_rs;
  logic haz_rt;

  assign haz_rs = pend_q[rs] && !byp1;
  assign haz_rt = rf.uses_rt && pend_q[rt] && !byp2;

  assign rf.read_data1    = rd1;
  assign rf.read_data2    = rd2;
  assign rf.extended_bits = extend(rf.ext_mode, imm, shamt);
  assign rf.stall         = haz_rs || haz_rt;
  assign rf.pending_vec   = pend_q;

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: reset state, write/read, r0, bypass,
// load-use scoreboard, set/clear race and all extender modes.
module tb_id_regfile_sb;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  id_regfile_sb_if #(.DATA_W(32)) rf_if ();

  id_regfile_sb #(.DATA_W(32), .SP_IDX(29), .SP_INIT(4000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'b000000, rs, rt, imm};
  endfunction

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    rf_if.RegWrite       = en;
    rf_if.write_register = r;
    rf_if.write_data     = d;
  endtask

  task automatic iss(input logic en, input logic [4:0] r);
    rf_if.issue_pending = en;
    rf_if.issue_dest    = r;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rf_if.instruction = '0;
    rf_if.uses_rt     = 1'b1;
    rf_if.ext_mode    = 2'b00;
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    rf_if.instruction = mk(5'd29, 5'd5, 16'h0);
    #1;
    chk("rst_sp", rf_if.read_data1, 32'd4000);
    chk("rst_r5", rf_if.read_data2, 32'd0);
    chk("rst_pend", rf_if.pending_vec, 32'd0);
    chk("rst_stall", rf_if.stall, 1'b0);

    // Dirty state, then an async reset pulse between edges
    wb(1'b1, 5'd5, 32'h77);
    iss(1'b1, 5'd12);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    iss(1'b0, 5'd0);
    rf_if.instruction = mk(5'd12, 5'd5, 16'h0);
    #1;
    chk("pre_pend", rf_if.pending_vec, 32'h0000_1000);
    chk("pre_stall", rf_if.stall, 1'b1);
    chk("pre_r5", rf_if.read_data2, 32'h77);
    rst_n = 1'b0;
    wb(1'b1, 5'd5, 32'h99);
    #1;
    chk("arst_pend", rf_if.pending_vec, 32'd0);
    chk("arst_stall", rf_if.stall, 1'b0);
    chk("arst_r5_nobyp", rf_if.read_data2, 32'd0);
    rf_if.instruction = mk(5'd29, 5'd5, 16'h0);
    #1;
    chk("arst_sp", rf_if.read_data1, 32'd4000);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_r5", rf_if.read_data2, 32'd0);

    // Write then read
    wb(1'b1, 5'd8, 32'hDEADBEEF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    rf_if.instruction = mk(5'd8, 5'd0, 16'h0);
    #1;
    chk("r8_read", rf_if.read_data1, 32'hDEADBEEF);

    // r0 discards writes, through bypass and storage
    wb(1'b1, 5'd0, 32'h1234);
    rf_if.instruction = mk(5'd0, 5'd0, 16'h0);
    #1;
    chk("r0_byp", rf_if.read_data1, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("r0_store", rf_if.read_data2, 32'd0);

    // X on RegWrite is no write and no bypass
    wb(1'bx, 5'd13, 32'hAA);
    rf_if.instruction = mk(5'd13, 5'd0, 16'h0);
    #1;
    chk("x_nobyp", rf_if.read_data1, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("x_nowrite", rf_if.read_data1, 32'd0);

    // Bypass on rt with the old value still in storage
    wb(1'b1, 5'd9, 32'h11);
    tick();
    wb(1'b1, 5'd9, 32'h55);
    rf_if.instruction = mk(5'd0, 5'd9, 16'h0);
    #1;
    chk("byp_rt", rf_if.read_data2, 32'h55);
    rf_if.RegWrite = 1'b0;
    #1;
    chk("byp_old", rf_if.read_data2, 32'h11);
    rf_if.RegWrite = 1'b1;
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("byp_stored", rf_if.read_data2, 32'h55);

    // Load-use on rs
    iss(1'b1, 5'd10);
    tick();
    iss(1'b0, 5'd0);
    rf_if.instruction = mk(5'd10, 5'd0, 16'h0);
    #1;
    chk("lu_stall0", rf_if.stall, 1'b1);
    chk("lu_pend", rf_if.pending_vec, 32'h0000_0400);
    tick();
    chk("lu_stall1", rf_if.stall, 1'b1);
    tick();
    chk("lu_stall2", rf_if.stall, 1'b1);
    wb(1'b1, 5'd10, 32'd7);
    #1;
    chk("lu_wb_stall", rf_if.stall, 1'b0);
    chk("lu_wb_data", rf_if.read_data1, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("lu_clr", rf_if.pending_vec, 32'd0);
    chk("lu_store", rf_if.read_data1, 32'd7);

    // rt hazard gated by uses_rt
    iss(1'b1, 5'd10);
    tick();
    iss(1'b0, 5'd0);
    rf_if.instruction = mk(5'd0, 5'd10, 16'h0);
    rf_if.uses_rt = 1'b0;
    #1;
    chk("rt_nouse", rf_if.stall, 1'b0);
    rf_if.uses_rt = 1'b1;
    #1;
    chk("rt_use", rf_if.stall, 1'b1);
    wb(1'b1, 5'd10, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'h0);

    // Set/clear race on one register: set wins
    iss(1'b1, 5'd11);
    wb(1'b1, 5'd11, 32'd3);
    tick();
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    rf_if.instruction = mk(5'd11, 5'd0, 16'h0);
    #1;
    chk("race_pend", rf_if.pending_vec, 32'h0000_0800);
    chk("race_data", rf_if.read_data1, 32'd3);
    chk("race_stall", rf_if.stall, 1'b1);

    // Extender
    rf_if.instruction = mk(5'd0, 5'd0, 16'h8001);
    rf_if.ext_mode = 2'b00;
    #1;
    chk("ext_sign", rf_if.extended_bits, 32'hFFFF8001);
    rf_if.ext_mode = 2'b01;
    #1;
    chk("ext_zero", rf_if.extended_bits, 32'h00008001);
    rf_if.ext_mode = 2'b10;
    #1;
    chk("ext_upper", rf_if.extended_bits, 32'h80010000);
    rf_if.instruction = mk(5'd0, 5'd0, 16'h07C0);
    rf_if.ext_mode = 2'b11;
    #1;
    chk("ext_shamt", rf_if.extended_bits, 32'h0000001F);
    rf_if.instruction = mk(5'd0, 5'd0, 16'h7FFF);
    rf_if.ext_mode = 2'b00;
    #1;
    chk("ext_sign_pos", rf_if.extended_bits, 32'h00007FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
